// File: rtl/knight_rider_monitor_if.sv
// Bus between a Knight Rider LED scanner (master) and its receive-side monitor (slave).
// Carries the qualified LED samples in one direction and the tracking status back.
interface knight_rider_monitor_if #(
  parameter int ERR_W   = 8,
  parameter int SWEEP_W = 16
);
  logic               sample_en;
  logic [7:0]         leds;
  logic               locked;
  logic [2:0]         pos;
  logic               dir;
  logic               error;
  logic               bounce;
  logic [ERR_W-1:0]   err_count;
  logic [SWEEP_W-1:0] sweep_count;

  modport master (
    output sample_en, leds,
    input  locked, pos, dir, error, bounce, err_count, sweep_count
  );

  modport slave (
    input  sample_en, leds,
    output locked, pos, dir, error, bounce, err_count, sweep_count
  );
endinterface

// File: rtl/knight_rider_monitor.sv
// Receive-side checker for an 8-bit Knight Rider scanner: locks onto the 3-LED
// window, tracks its position and direction, flags sequence breaks and counts bounces.
module knight_rider_monitor #(
  parameter int ERR_W   = 8,
  parameter int SWEEP_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  knight_rider_monitor_if.slave bus
);

  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

  localparam logic [ERR_W-1:0]   ERR_ONE   = 1;
  localparam logic [SWEEP_W-1:0] SWEEP_ONE = 1;

  state_t             state, state_next;
  logic [2:0]         pos, pos_next;
  logic               dir, dir_next;
  logic               error, error_next;
  logic               bounce, bounce_next;
  logic [ERR_W-1:0]   err_count, err_next;
  logic [SWEEP_W-1:0] sweep_count, sweep_next;

  logic               legal;
  logic [2:0]         p;
  logic [2:0]         exp_pos;
  logic               exp_dir;

  // A sample is legal only if it is exactly the 3-LED window at one of six offsets.
  always_comb begin
    legal = 1'b0;
    p     = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (bus.leds == (8'h07 << i)) begin
        legal = 1'b1;
        p     = 3'(i);
      end
    end
  end

  always_comb begin
    exp_pos = pos;
    exp_dir = dir;
    if (!dir) begin
      if (pos < 3'd5) begin
        exp_pos = pos + 3'd1;
        exp_dir = 1'b0;
      end else begin
        exp_pos = 3'd4;
        exp_dir = 1'b1;
      end
    end else begin
      if (pos > 3'd0) begin
        exp_pos = pos - 3'd1;
        exp_dir = 1'b1;
      end else begin
        exp_pos = 3'd1;
        exp_dir = 1'b0;
      end
    end
  end

  always_comb begin
    state_next  = state;
    pos_next    = pos;
    dir_next    = dir;
    error_next  = 1'b0;
    bounce_next = 1'b0;
    err_next    = err_count;
    sweep_next  = sweep_count;
    if (bus.sample_en) begin
      case (state)
        UNLOCKED: begin
          if (legal) begin
            pos_next   = p;
            state_next = ACQUIRE;
          end
        end
        // Two adjacent legal samples establish both position and direction.
        ACQUIRE: begin
          if (!legal) begin
            state_next = UNLOCKED;
          end else begin
            pos_next = p;
            if (p == pos + 3'd1) begin
              dir_next   = 1'b0;
              state_next = LOCKED;
            end else if (p == pos - 3'd1) begin
              dir_next   = 1'b1;
              state_next = LOCKED;
            end
          end
        end
        LOCKED: begin
          if (legal && (p == exp_pos)) begin
            pos_next = exp_pos;
            dir_next = exp_dir;
            if (exp_dir != dir) begin
              bounce_next = 1'b1;
              sweep_next  = sweep_count + SWEEP_ONE;
            end
          end else begin
            error_next = 1'b1;
            if (err_count != '1) err_next = err_count + ERR_ONE;
            if (legal) begin
              pos_next   = p;
              state_next = ACQUIRE;
            end else begin
              state_next = UNLOCKED;
            end
          end
        end
        default: state_next = UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= UNLOCKED;
      pos         <= 3'd0;
      dir         <= 1'b0;
      error       <= 1'b0;
      bounce      <= 1'b0;
      err_count   <= '0;
      sweep_count <= '0;
    end else begin
      state       <= state_next;
      pos         <= pos_next;
      dir         <= dir_next;
      error       <= error_next;
      bounce      <= bounce_next;
      err_count   <= err_next;
      sweep_count <= sweep_next;
    end
  end

  assign bus.locked      = (state == LOCKED);
  assign bus.pos         = pos;
  assign bus.dir         = dir;
  assign bus.error       = error;
  assign bus.bounce      = bounce;
  assign bus.err_count   = err_count;
  assign bus.sweep_count = sweep_count;

endmodule

// File: tb/tb_knight_rider_monitor.sv
// Directed bench for knight_rider_monitor; a second instance with a 2-bit error
// counter shares the same stimulus so saturation can be observed alongside.
module tb_knight_rider_monitor;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] leds;
    logic       locked;
    logic [2:0] pos;
    logic       dir;
    logic       error;
    logic       bounce;
    int         ec;
    int         sc;
  } vec_t;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs[$];

  knight_rider_monitor_if #(.ERR_W(8), .SWEEP_W(16)) bus ();
  knight_rider_monitor_if #(.ERR_W(2), .SWEEP_W(16)) bus_s ();

  assign bus_s.sample_en = bus.sample_en;
  assign bus_s.leds      = bus.leds;

  knight_rider_monitor #(.ERR_W(8), .SWEEP_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  knight_rider_monitor #(.ERR_W(2), .SWEEP_W(16)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(logic r, logic en, logic [7:0] l, logic lk, logic [2:0] p,
                              logic d, logic e, logic b, int ec, int sc);
    vec_t v;
    v.rst = r;  v.en = en;  v.leds = l;
    v.locked = lk;  v.pos = p;  v.dir = d;
    v.error = e;  v.bounce = b;  v.ec = ec;  v.sc = sc;
    return v;
  endfunction

  task automatic cmp(input string name, input int idx, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s (step %0d): got %0d, want %0d", name, idx, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst           = v.rst;
    bus.sample_en = v.en;
    bus.leds      = v.leds;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    cmp("locked",        idx, int'(bus.locked),        int'(v.locked));
    cmp("pos",           idx, int'(bus.pos),           int'(v.pos));
    cmp("dir",           idx, int'(bus.dir),           int'(v.dir));
    cmp("error",         idx, int'(bus.error),         int'(v.error));
    cmp("bounce",        idx, int'(bus.bounce),        int'(v.bounce));
    cmp("err_count",     idx, int'(bus.err_count),     v.ec);
    cmp("sweep_count",   idx, int'(bus.sweep_count),   v.sc);
    cmp("err_count_sat", idx, int'(bus_s.err_count),   (v.ec > 3) ? 3 : v.ec);
  endtask

  task automatic runVec(input vec_t v, input int idx);
    applyStimulus(v);
    checkOutput(v, idx);
  endtask

  // One scanner period starting after a lock at pos=1 dir=0.
  int pos_seq [10] = '{2, 3, 4, 5, 4, 3, 2, 1, 0, 1};
  int dir_seq [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 0};
  int bnc_seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  initial begin
    int         sc;
    logic [7:0] l;
    rst           = 1'b1;
    bus.sample_en = 1'b0;
    bus.leds      = 8'h00;

    // Reset, lock-on, three full periods
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'h07, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'h0E, 1, 1, 0, 0, 0, 0, 0));
    sc = 0;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 10; j++) begin
        sc += bnc_seq[j];
        l = 8'h07 << pos_seq[j];
        vecs.push_back(mk(0, 1, l, 1, 3'(pos_seq[j]), dir_seq[j] != 0, 0, bnc_seq[j] != 0, 0, sc));
      end
    end

    // Position error then relock in the opposite direction
    vecs.push_back(mk(0, 1, 8'h1C, 1, 2, 0, 0, 0, 0, 6));
    vecs.push_back(mk(0, 1, 8'h70, 0, 4, 0, 1, 0, 1, 6));
    vecs.push_back(mk(0, 1, 8'h38, 1, 3, 1, 0, 0, 1, 6));

    // Illegal pattern, then blank samples raise nothing
    vecs.push_back(mk(0, 1, 8'h05, 0, 3, 1, 1, 0, 2, 6));
    for (int j = 0; j < 3; j++) vecs.push_back(mk(0, 1, 8'h00, 0, 3, 1, 0, 0, 2, 6));
    vecs.push_back(mk(0, 1, 8'h07, 0, 0, 1, 0, 0, 2, 6));
    vecs.push_back(mk(0, 1, 8'h0E, 1, 1, 0, 0, 0, 2, 6));

    // Gated cycles with garbage on the bus
    for (int j = 0; j < 20; j++) begin
      l = 8'(j * 37 + 5);
      vecs.push_back(mk(0, 0, l, 1, 1, 0, 0, 0, 2, 6));
    end

    // Five more errors; the 2-bit instance pins at 3
    vecs.push_back(mk(0, 1, 8'h38, 0, 3, 0, 1, 0, 3, 6));
    vecs.push_back(mk(0, 1, 8'h1C, 1, 2, 1, 0, 0, 3, 6));
    vecs.push_back(mk(0, 1, 8'h70, 0, 4, 1, 1, 0, 4, 6));
    vecs.push_back(mk(0, 1, 8'h38, 1, 3, 1, 0, 0, 4, 6));
    vecs.push_back(mk(0, 1, 8'h07, 0, 0, 1, 1, 0, 5, 6));
    vecs.push_back(mk(0, 1, 8'h0E, 1, 1, 0, 0, 0, 5, 6));
    vecs.push_back(mk(0, 1, 8'hE0, 0, 5, 0, 1, 0, 6, 6));
    vecs.push_back(mk(0, 1, 8'h70, 1, 4, 1, 0, 0, 6, 6));
    vecs.push_back(mk(0, 1, 8'h05, 0, 4, 1, 1, 0, 7, 6));
    vecs.push_back(mk(0, 0, 8'h0E, 0, 4, 1, 0, 0, 7, 6));

    for (int i = 0; i < vecs.size(); i++) runVec(vecs[i], i);

    // Reset mid-run while locked with sweep_count=4
    runVec(mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0), 1000);
    runVec(mk(0, 1, 8'h07, 0, 0, 0, 0, 0, 0, 0), 1001);
    runVec(mk(0, 1, 8'h0E, 1, 1, 0, 0, 0, 0, 0), 1002);
    sc = 0;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 10; j++) begin
        sc += bnc_seq[j];
        l = 8'h07 << pos_seq[j];
        runVec(mk(0, 1, l, 1, 3'(pos_seq[j]), dir_seq[j] != 0, 0, bnc_seq[j] != 0, 0, sc),
               1003 + k * 10 + j);
      end
    end
    runVec(mk(1, 1, 8'h1C, 0, 0, 0, 0, 0, 0, 0), 1100);
    runVec(mk(0, 1, 8'h1C, 0, 2, 0, 0, 0, 0, 0), 1101);
    runVec(mk(0, 1, 8'h38, 1, 3, 0, 0, 0, 0, 0), 1102);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/knight_rider_monitor.md
Name: knight_rider_monitor

Overview:
- Receive-side checker for the 8-bit Knight Rider LED scanner.
- The scanner drives a 3-LED window that starts at 8'b0000_0111. It shifts left one position per step up to 8'b1110_0000, then shifts right back to 8'b0000_0111, then repeats.
- This block samples the LED bus, locks onto the pattern, and tracks window position and direction.
- It flags every step that breaks the scan sequence and counts end-of-travel bounces. Intended for self-checking benches and on-board status.

Parameters:
ERR_W  8  width of saturating error counter
SWEEP_W  16  width of wrapping bounce counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
sample_en  input  1  qualifies leds; one scanner step per asserted cycle
leds  input  8  LED bus from the scanner
locked  output  1  high while the tracked sequence is valid
pos  output  3  index of lowest lit LED of the current window (0..5)
dir  output  1  0 = window moving left (toward bit 7), 1 = moving right
error  output  1  one-cycle pulse on a sequence violation
bounce  output  1  one-cycle pulse when direction reverses while locked
err_count  output  ERR_W  number of violations, saturates at all-ones
sweep_count  output  SWEEP_W  number of bounces, wraps to 0

Behaviour:
- Legal window: leds == 8'b0000_0111 << p for p in 0..5. Decoded p = index of lowest set bit. Any other value, including 0, is illegal.
- All outputs are registered. They update on the clk edge where sample_en=1, so they are visible 1 cycle after the sample.
- With sample_en=0: state, pos, dir and counters hold; error and bounce are 0.
- Reset (rst=1 at a clk edge):
  - state=UNLOCKED; locked=0, pos=0, dir=0, error=0, bounce=0, err_count=0, sweep_count=0.
  - Reset has priority over sample_en. Reset mid-operation discards lock immediately.
- States: UNLOCKED, ACQUIRE, LOCKED. locked=1 only in LOCKED.
- UNLOCKED:
  - Legal sample: pos<=p, go to ACQUIRE.
  - Illegal sample: stay. No error is raised (not yet locked).
- ACQUIRE:
  - Legal p with p==pos+1: dir<=0, pos<=p, go to LOCKED.
  - Legal p with p==pos-1: dir<=1, pos<=p, go to LOCKED.
  - Other legal p: pos<=p, stay in ACQUIRE.
  - Illegal sample: go to UNLOCKED.
  - No error is raised in this state.
- LOCKED, expected next position e and direction d:
  - dir=0, pos<5: e=pos+1, d=0.
  - dir=0, pos==5: e=4, d=1.
  - dir=1, pos>0: e=pos-1, d=1.
  - dir=1, pos==0: e=1, d=0.
  - Match (legal and p==e): pos<=e, dir<=d. If d!=dir: bounce=1 and sweep_count+1, wrapping modulo 2^SWEEP_W.
  - Mismatch: error=1, err_count+1 unless already all-ones. Then, if the sample is legal, pos<=p and go to ACQUIRE; otherwise go to UNLOCKED. No bounce on a mismatch.
- error and bounce are never asserted in the same cycle.
- Full scanner period is 10 steps, with 2 bounces per period.

Test Plan:
- Lock-on:
  - Stimulus: rst, then samples 0x07, 0x0E.
  - Response: 1 cycle after 0x0E, locked=1, pos=1, dir=0, error=0.
- Full sweeps:
  - Stimulus: continue the generator sequence for 3 periods.
  - Response: pos follows 2,3,4,5,4,3,2,1,0,1,...; bounce pulses when pos reaches 4 after 5 and 1 after 0; sweep_count=6; err_count=0.
- Position error:
  - Stimulus: while locked at pos=2 dir=0, feed 0x38 (p=3 expected) replaced by 0x70.
  - Response: error pulse, err_count=1, locked=0. Then feed 0x38: relock with pos=3, dir=1.
- Illegal pattern:
  - Stimulus: while locked, feed 0x05.
  - Response: error pulse, state UNLOCKED.
  - Stimulus: further 0x00 samples.
  - Response: no additional errors.
- Gating and saturation:
  - Stimulus: sample_en low for 20 cycles while locked.
  - Response: all outputs held, no pulses.
  - Stimulus: with ERR_W=2, inject 5 errors.
  - Response: err_count stays at 3.
- Reset mid-run:
  - Stimulus: assert rst for one cycle while locked at sweep_count=4.
  - Response: all outputs at reset values next cycle, and a fresh lock-on is required.
